// File: rtl/cache_flush_walker_if.sv
// Flush-walker signal bundle: flush request/completion handshakes plus tag-stage walk, stall,
// eviction and writeback-ack lines.
interface cache_flush_walker_if #(
  parameter int unsigned LSB      = 4,
  parameter int unsigned NUM_WAYS = 1
);
  logic                flush_req_valid;
  logic                flush_req_ready;
  logic                flush_done_valid;
  logic                flush_done_ready;
  logic                busy;
  logic                init;
  logic                flush_line;
  logic [LSB-1:0]      line_sel;
  logic [NUM_WAYS-1:0] flush_way_sel;
  logic                pipe_stall;
  logic                eviction;
  logic                wb_ack;

  modport master (
    input  flush_req_valid, flush_done_ready, pipe_stall, eviction, wb_ack,
    output flush_req_ready, flush_done_valid, busy, init, flush_line, line_sel, flush_way_sel
  );

  modport slave (
    output flush_req_valid, flush_done_ready, pipe_stall, eviction, wb_ack,
    input  flush_req_ready, flush_done_valid, busy, init, flush_line, line_sel, flush_way_sel
  );
endinterface

// File: rtl/cache_flush_walker.sv
// Init/flush line walker in front of the bank tag stage; tracks dirty evictions until their
// writebacks are acknowledged, then reports flush completion.
module cache_flush_walker #(
  parameter int unsigned CACHE_SIZE = 1024,
  parameter int unsigned LINE_SIZE  = 16,
  parameter int unsigned NUM_BANKS  = 1,
  parameter int unsigned NUM_WAYS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  cache_flush_walker_if.master  io_walk
);
  localparam int unsigned LINES_PER_BANK = CACHE_SIZE / (LINE_SIZE * NUM_BANKS);
  localparam int unsigned LSB      = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1;
  localparam int unsigned WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned WB_CNT_W = $clog2(LINES_PER_BANK * NUM_WAYS + 1);

  localparam logic [LSB-1:0]   LAST_LINE = LSB'(LINES_PER_BANK - 1);
  localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(NUM_WAYS - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [LSB-1:0]      r_line_cnt, w_line_nxt;
  logic [WAY_W-1:0]    r_way_cnt, w_way_nxt;
  logic [WB_CNT_W-1:0] r_wb_cnt, w_wb_nxt;
  logic                r_acc_q;
  logic                w_accept, w_wb_inc, w_wb_dec;

  logic                w_req_ready_d, w_done_valid_d, w_busy_d, w_init_d, w_flush_line_d;
  logic [LSB-1:0]      w_line_sel_d;
  logic [NUM_WAYS-1:0] w_way_sel_d;

  assign w_accept = (r_state == S_FLUSH) && !io_walk.pipe_stall;
  // The eviction flag belongs to the op accepted on the previous cycle.
  assign w_wb_inc = r_acc_q && io_walk.eviction && (r_state != S_INIT);
  assign w_wb_dec = io_walk.wb_ack && (r_wb_cnt != '0);

  always_comb begin
    w_wb_nxt = r_wb_cnt;
    if (w_wb_inc && !w_wb_dec)      w_wb_nxt = r_wb_cnt + WB_CNT_W'(1);
    else if (!w_wb_inc && w_wb_dec) w_wb_nxt = r_wb_cnt - WB_CNT_W'(1);
  end

  // State and walk counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_line_cnt <= '0;
      r_way_cnt  <= '0;
      r_wb_cnt   <= '0;
      r_acc_q    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_line_cnt <= w_line_nxt;
      r_way_cnt  <= w_way_nxt;
      r_wb_cnt   <= w_wb_nxt;
      r_acc_q    <= w_accept;
    end
  end

  // Next-state and counter advance.
  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line_cnt;
    w_way_nxt   = r_way_cnt;
    unique case (r_state)
      S_INIT: begin
        if (r_line_cnt == LAST_LINE) begin
          w_line_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_line_nxt = r_line_cnt + LSB'(1);
        end
      end
      S_IDLE: begin
        if (io_walk.flush_req_valid) begin
          w_state_nxt = S_FLUSH;
          w_line_nxt  = '0;
          w_way_nxt   = '0;
        end
      end
      S_FLUSH: begin
        if (w_accept) begin
          if (r_way_cnt == LAST_WAY) begin
            w_way_nxt = '0;
            if (r_line_cnt == LAST_LINE) begin
              w_line_nxt  = '0;
              w_state_nxt = S_DRAIN;
            end else begin
              w_line_nxt = r_line_cnt + LSB'(1);
            end
          end else begin
            w_way_nxt = r_way_cnt + WAY_W'(1);
          end
        end
      end
      // Using the next count folds the last eviction sample into the exit decision.
      S_DRAIN: if (w_wb_nxt == '0) w_state_nxt = S_DONE;
      S_DONE:  if (io_walk.flush_done_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Output decode of the upcoming state, registered below.
  always_comb begin
    w_req_ready_d  = 1'b0;
    w_done_valid_d = 1'b0;
    w_busy_d       = 1'b1;
    w_init_d       = 1'b0;
    w_flush_line_d = 1'b0;
    w_line_sel_d   = w_line_nxt;
    w_way_sel_d    = '0;
    unique case (w_state_nxt)
      S_INIT:  w_init_d = 1'b1;
      S_IDLE: begin
        w_req_ready_d = 1'b1;
        w_busy_d      = 1'b0;
      end
      S_FLUSH: begin
        w_flush_line_d = 1'b1;
        w_way_sel_d    = NUM_WAYS'(1) << w_way_nxt;
      end
      S_DONE:  w_done_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_walk.flush_req_ready  <= 1'b0;
      io_walk.flush_done_valid <= 1'b0;
      io_walk.busy             <= 1'b1;
      io_walk.init             <= 1'b1;
      io_walk.flush_line       <= 1'b0;
      io_walk.line_sel         <= '0;
      io_walk.flush_way_sel    <= '0;
    end else begin
      io_walk.flush_req_ready  <= w_req_ready_d;
      io_walk.flush_done_valid <= w_done_valid_d;
      io_walk.busy             <= w_busy_d;
      io_walk.init             <= w_init_d;
      io_walk.flush_line       <= w_flush_line_d;
      io_walk.line_sel         <= w_line_sel_d;
      io_walk.flush_way_sel    <= w_way_sel_d;
    end
  end

  // A writeback ack with nothing outstanding is dropped by the counter; flag it in simulation.
  a_wb_ack_underflow: assert property (@(posedge clk) disable iff (reset)
    !(io_walk.wb_ack && (r_wb_cnt == '0)));
endmodule

// File: tb/tb_cache_flush_walker.sv
// Directed bench for cache_flush_walker: 16 lines x 2 ways.
module tb_cache_flush_walker;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cache_flush_walker_if #(.LSB(4), .NUM_WAYS(2)) bus ();

  cache_flush_walker #(
    .CACHE_SIZE(1024), .LINE_SIZE(64), .NUM_BANKS(1), .NUM_WAYS(2)
  ) dut (
    .clk(clk), .reset(reset), .io_walk(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results recorded by run_flush, cycle 0 = first FLUSH cycle.
  int op_line [64];
  int op_way  [64];
  int wb_hist [256];
  int n_ops, last_op_cyc, done_cyc, wb_peak, busy_low, hold_bad, hold_line, hold_way, stall_used;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a flush from IDLE and drives stall/eviction/ack stimulus until done is seen.
  task automatic run_flush(input logic [63:0] evict_mask, input int stall_op, input int stall_len,
                           input int ack_delay);
    int ack_at[$];
    int prev_acc;
    n_ops = 0; last_op_cyc = -1; done_cyc = -1; wb_peak = 0; busy_low = 0;
    hold_bad = 0; hold_line = -1; hold_way = -1; stall_used = 0; prev_acc = -1;
    bus.flush_req_valid = 1'b1;
    step();
    bus.flush_req_valid = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      wb_hist[cyc] = int'(dut.r_wb_cnt);
      if (wb_hist[cyc] > wb_peak) wb_peak = wb_hist[cyc];
      if (bus.flush_done_valid) begin
        done_cyc = cyc;
        break;
      end
      if (!bus.busy) busy_low++;
      bus.eviction = (prev_acc >= 0) && evict_mask[prev_acc];
      if (bus.eviction) ack_at.push_back(cyc + ack_delay);
      bus.wb_ack = 1'b0;
      if (ack_at.size() > 0 && ack_at[0] == cyc) begin
        bus.wb_ack = 1'b1;
        void'(ack_at.pop_front());
      end
      bus.pipe_stall = 1'b0;
      if (bus.flush_line && n_ops == stall_op && stall_used < stall_len) begin
        if (stall_used == 0) begin
          hold_line = int'(bus.line_sel);
          hold_way  = int'(bus.flush_way_sel);
        end else if (int'(bus.line_sel) != hold_line || int'(bus.flush_way_sel) != hold_way) begin
          hold_bad++;
        end
        stall_used++;
        bus.pipe_stall = 1'b1;
      end
      prev_acc = -1;
      if (bus.flush_line && !bus.pipe_stall) begin
        op_line[n_ops] = int'(bus.line_sel);
        op_way[n_ops]  = int'(bus.flush_way_sel);
        prev_acc       = n_ops;
        last_op_cyc    = cyc;
        n_ops++;
      end
      step();
    end
    bus.eviction = 1'b0; bus.wb_ack = 1'b0; bus.pipe_stall = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.flush_req_valid = 1'b0; bus.flush_done_ready = 1'b0;
    bus.pipe_stall = 1'b0; bus.eviction = 1'b0; bus.wb_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++; if (bus.init !== 1'b1) begin errors++; $display("FAIL reset_init got %b exp 1", bus.init); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", bus.busy); end
    checks++; if (bus.flush_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.flush_req_ready); end
    checks++; if (bus.flush_done_valid !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.flush_done_valid); end
    checks++; if (bus.flush_line !== 1'b0) begin errors++; $display("FAIL reset_flush_line got %b exp 0", bus.flush_line); end
    checks++; if (bus.flush_way_sel !== 2'b00) begin errors++; $display("FAIL reset_way_sel got %b exp 00", bus.flush_way_sel); end
    checks++; if (dut.r_wb_cnt !== '0) begin errors++; $display("FAIL reset_wb_cnt got %0d exp 0", dut.r_wb_cnt); end
  endtask

  task automatic test_init_walk();
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.init !== 1'b1 || int'(bus.line_sel) != i) begin
        errors++; $display("FAIL init_line%0d got init=%b line=%0d exp init=1 line=%0d", i, bus.init, bus.line_sel, i);
      end
      checks++; if (bus.flush_req_ready !== 1'b0) begin errors++; $display("FAIL init_ready%0d got %b exp 0", i, bus.flush_req_ready); end
      step();
    end
    checks++; if (bus.init !== 1'b0) begin errors++; $display("FAIL init_end got %b exp 0", bus.init); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bus.busy); end
    checks++; if (bus.flush_req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", bus.flush_req_ready); end
  endtask

  task automatic test_flush_basic();
    run_flush(64'd0, -1, 0, 5);
    checks++; if (n_ops != 32) begin errors++; $display("FAIL basic_ops got %0d exp 32", n_ops); end
    for (int k = 0; k < 32; k++) begin
      checks++; if (op_line[k] != k / 2 || op_way[k] != (1 << (k % 2))) begin
        errors++; $display("FAIL basic_order%0d got line=%0d way=%0d exp line=%0d way=%0d", k, op_line[k], op_way[k], k / 2, 1 << (k % 2));
      end
    end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL basic_busy got %0d idle cycles exp 0", busy_low); end
    checks++; if (last_op_cyc != 31) begin errors++; $display("FAIL basic_last_op got %0d exp 31", last_op_cyc); end
    checks++; if (done_cyc != 33) begin errors++; $display("FAIL basic_done_cyc got %0d exp 33", done_cyc); end
    // Completion withheld for three cycles while a new request knocks.
    bus.flush_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.flush_done_valid !== 1'b1 || bus.flush_req_ready !== 1'b0 || bus.flush_line !== 1'b0) begin
        errors++; $display("FAIL done_hold%0d got done=%b ready=%b fl=%b exp 1 0 0", i, bus.flush_done_valid, bus.flush_req_ready, bus.flush_line);
      end
    end
    bus.flush_req_valid = 1'b0;
    bus.flush_done_ready = 1'b1;
    step();
    bus.flush_done_ready = 1'b0;
    checks++; if (bus.flush_done_valid !== 1'b0 || bus.flush_req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL done_release got done=%b ready=%b busy=%b exp 0 1 0", bus.flush_done_valid, bus.flush_req_ready, bus.busy);
    end
  endtask

  task automatic test_stall();
    run_flush(64'd0, 15, 4, 5);
    checks++; if (hold_line != 7 || hold_way != 2) begin errors++; $display("FAIL stall_pos got line=%0d way=%0d exp 7 2", hold_line, hold_way); end
    checks++; if (stall_used != 4 || hold_bad != 0) begin errors++; $display("FAIL stall_hold got used=%0d bad=%0d exp 4 0", stall_used, hold_bad); end
    checks++; if (n_ops != 32) begin errors++; $display("FAIL stall_ops got %0d exp 32", n_ops); end
    for (int k = 0; k < 32; k++) begin
      checks++; if (op_line[k] != k / 2 || op_way[k] != (1 << (k % 2))) begin
        errors++; $display("FAIL stall_order%0d got line=%0d way=%0d exp line=%0d way=%0d", k, op_line[k], op_way[k], k / 2, 1 << (k % 2));
      end
    end
    checks++; if (done_cyc != 37) begin errors++; $display("FAIL stall_done_cyc got %0d exp 37", done_cyc); end
    bus.flush_done_ready = 1'b1; step(); bus.flush_done_ready = 1'b0;
    checks++; if (bus.flush_req_ready !== 1'b1) begin errors++; $display("FAIL stall_idle got %b exp 1", bus.flush_req_ready); end
  endtask

  task automatic test_evictions();
    logic [63:0] m;
    m = '0; m[3] = 1'b1; m[10] = 1'b1; m[31] = 1'b1;
    run_flush(m, -1, 0, 5);
    checks++; if (wb_peak != 1) begin errors++; $display("FAIL evict_peak got %0d exp 1", wb_peak); end
    checks++; if (wb_hist[5] != 1 || wb_hist[10] != 0) begin errors++; $display("FAIL evict_count got %0d,%0d exp 1,0", wb_hist[5], wb_hist[10]); end
    checks++; if (wb_hist[33] != 1) begin errors++; $display("FAIL evict_drain_cnt got %0d exp 1", wb_hist[33]); end
    checks++; if (done_cyc != 38) begin errors++; $display("FAIL evict_done_cyc got %0d exp 38", done_cyc); end
    bus.flush_done_ready = 1'b1; step(); bus.flush_done_ready = 1'b0;
    checks++; if (bus.flush_req_ready !== 1'b1) begin errors++; $display("FAIL evict_idle got %b exp 1", bus.flush_req_ready); end
  endtask

  task automatic test_coincident_ack();
    logic [63:0] m;
    m = '0; m[26] = 1'b1; m[31] = 1'b1;
    run_flush(m, -1, 0, 5);
    checks++; if (wb_hist[32] != 1 || wb_hist[33] != 1) begin errors++; $display("FAIL coinc_cnt got %0d,%0d exp 1,1", wb_hist[32], wb_hist[33]); end
    checks++; if (wb_peak != 1) begin errors++; $display("FAIL coinc_peak got %0d exp 1", wb_peak); end
    checks++; if (done_cyc != 38) begin errors++; $display("FAIL coinc_done_cyc got %0d exp 38", done_cyc); end
    bus.flush_done_ready = 1'b1; step(); bus.flush_done_ready = 1'b0;
    checks++; if (bus.flush_req_ready !== 1'b1) begin errors++; $display("FAIL coinc_idle got %b exp 1", bus.flush_req_ready); end
  endtask

  task automatic test_reset_mid_flush();
    logic ev_next, seen;
    ev_next = 1'b0; seen = 1'b0;
    bus.flush_req_valid = 1'b1; step(); bus.flush_req_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.eviction = ev_next;
      ev_next = 1'b0;
      if (bus.flush_line && int'(bus.line_sel) == 9) begin
        seen = 1'b1;
        break;
      end
      if (bus.flush_line && int'(bus.line_sel) == 8 && bus.flush_way_sel == 2'b01) ev_next = 1'b1;
      step();
    end
    bus.eviction = 1'b0;
    checks++; if (seen !== 1'b1 || dut.r_wb_cnt != 1) begin errors++; $display("FAIL midrst_pre got seen=%b wb=%0d exp 1 1", seen, dut.r_wb_cnt); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (bus.flush_line !== 1'b0 || bus.flush_way_sel !== 2'b00) begin errors++; $display("FAIL midrst_flush got fl=%b way=%b exp 0 00", bus.flush_line, bus.flush_way_sel); end
    checks++; if (bus.init !== 1'b1 || bus.line_sel !== 4'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_init got init=%b line=%0d busy=%b exp 1 0 1", bus.init, bus.line_sel, bus.busy); end
    checks++; if (dut.r_wb_cnt !== '0) begin errors++; $display("FAIL midrst_wb got %0d exp 0", dut.r_wb_cnt); end
    step();
    checks++; if (bus.init !== 1'b1 || bus.line_sel !== 4'd1) begin errors++; $display("FAIL midrst_line1 got init=%b line=%0d exp 1 1", bus.init, bus.line_sel); end
    repeat (15) step();
    checks++; if (bus.init !== 1'b0 || bus.flush_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle got init=%b ready=%b exp 0 1", bus.init, bus.flush_req_ready); end
  endtask

  initial begin
    test_reset();
    test_init_walk();
    test_flush_basic();
    test_stall();
    test_evictions();
    test_coincident_ack();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_flush_walker.md
Name: cache_flush_walker

Overview:
- Sequencer that sits directly upstream of the bank tag stage.
- Generates the per-line invalidate walk (init) after reset, and the per-line/per-way flush walk (flush_line, flush_way_sel) on a flush request.
- Counts dirty evictions reported back by the tag stage, and waits for their memory writeback acks before signalling completion.
- Blocks core requests from the bank while any walk is in progress.

Parameters:
- CACHE_SIZE, 1024, cache size in bytes
- LINE_SIZE, 16, line size in bytes
- NUM_BANKS, 1, number of banks
- NUM_WAYS, 1, associativity
- LINES_PER_BANK, derived as CACHE_SIZE/(LINE_SIZE*NUM_BANKS). LSB = max(1, clog2(LINES_PER_BANK)).
- WB_CNT_W, derived as clog2(LINES_PER_BANK*NUM_WAYS+1), width of the outstanding-writeback counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush_req_valid  in  1  core/DCR flush request
- flush_req_ready  out  1  request accepted this cycle when valid&&ready
- flush_done_valid  out  1  flush complete
- flush_done_ready  in  1  consumer takes completion
- busy  out  1  walk or drain in progress; bank gates core requests with it
- init  out  1  invalidate current line (to tag stage)
- flush_line  out  1  flush current line/way (to tag stage)
- line_sel  out  LSB  line index driven to tag stage
- flush_way_sel  out  NUM_WAYS  one-hot way under flush
- pipe_stall  in  1  tag stage stall; an op is accepted only when ~pipe_stall
- eviction  in  1  tag stage eviction flag for the op accepted last cycle
- wb_ack  in  1  memory writeback completion pulse

Behaviour:
- States: INIT, IDLE, FLUSH, DRAIN, DONE.
- Reset values:
  - state=INIT, line_cnt=0, way_cnt=0, wb_cnt=0
  - flush_req_ready=0, flush_done_valid=0, busy=1
  - flush_line=0, flush_way_sel=0, init asserted from the first cycle after reset
- INIT:
  - init=1, line_sel=line_cnt, busy=1.
  - Init is unconditional: the tag stage writes on init regardless of pipe_stall.
  - line_cnt increments every cycle.
  - At line_cnt==LINES_PER_BANK-1: line_cnt<=0, goto IDLE. Exactly LINES_PER_BANK init cycles.
- IDLE:
  - busy=0, flush_req_ready=1.
  - On flush_req_valid: goto FLUSH with line_cnt=0, way_cnt=0.
- FLUSH:
  - flush_line=1, line_sel=line_cnt, flush_way_sel=onehot(way_cnt).
  - An op is accepted when ~pipe_stall. On acceptance, way_cnt increments.
  - When way_cnt wraps from NUM_WAYS-1, line_cnt increments.
  - When pipe_stall is high, all outputs hold.
  - After the last op (line LINES_PER_BANK-1, way NUM_WAYS-1) is accepted: goto DRAIN.
- Eviction accounting:
  - eviction is sampled exactly one cycle after each accepted flush op (registered acc_q flag).
  - If acc_q&&eviction, wb_cnt increments.
  - A wb_ack in the same cycle decrements. Simultaneous increment and decrement leaves wb_cnt unchanged.
  - eviction is ignored when acc_q=0 or during INIT.
  - wb_ack while wb_cnt==0 is ignored: saturate at 0; assertion fires in sim.
- DRAIN:
  - busy=1. Waits one cycle for the last eviction sample.
  - Then, when wb_cnt==0, goto DONE.
- DONE:
  - flush_done_valid=1, busy=1.
  - On flush_done_ready: goto IDLE.
- flush_req_valid is ignored outside IDLE; flush_req_ready=0 there.
- Reset mid-walk restarts INIT, and wb_cnt clears. Outstanding acks arriving after reset hit the saturation rule.
- NUM_WAYS==1: flush_way_sel is constant 1 in FLUSH and way_cnt is unused.
- Outputs are registered. init, flush_line and flush_way_sel are 0 whenever their state is not active.

Test Plan:
- Config CACHE_SIZE=1024, LINE_SIZE=64, NUM_BANKS=1, NUM_WAYS=2 (16 lines).
- Reset released -> init high for exactly 16 cycles with line_sel 0..15, then busy=0 and flush_req_ready=1.
- Flush with pipe_stall=0 and no evictions -> 32 flush ops, order (line0,way01),(line0,way10),(line1,way01)..., then flush_done_valid within 2 cycles of the last op.
- Evictions on ops 3, 10 and 31, with wb_ack returned 5 cycles after each -> wb_cnt peaks at 1 or 2; flush_done_valid only after the third ack.
- pipe_stall high for 4 cycles mid-walk at line 7 way 1 -> outputs hold, and no op is skipped or duplicated (total still 32).
- wb_ack coincident with an eviction sample -> wb_cnt unchanged. flush_done_ready held low for 3 cycles in DONE -> done held, flush_req_valid ignored.
- Reset asserted at line 9 of FLUSH -> INIT restarts at line 0, wb_cnt=0, flush_line=0 the cycle after reset.
